// File: rtl/mem_stage_ws.sv
// MEM pipeline stage: word-organised data memory with byte/half/word access,
// misalignment detection, optional wait states and a registered MEM/WB boundary.
module mem_stage_ws #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        res,
    input  logic        ex_valid,
    input  logic [7:0]  ex_ctrl,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic        ex_zero,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_data,
    output logic        mem_busy,
    output logic        mem_wb_valid,
    output logic [7:0]  mem_wb_control,
    output logic [31:0] mem_wb_memdata,
    output logic [31:0] mem_wb_regdata,
    output logic [31:0] mem_wb_pc,
    output logic        pcsrc_flag,
    output logic        misalign_flag
);
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam int       DEPTH     = 1 << ADDR_W;
    localparam logic     HAS_WAIT  = (WAIT_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    // Access size code: 0 none, 1 byte, 2 half, 3 word
    function automatic logic [1:0] access_size(input logic [2:0] f3, input logic store);
        case (f3)
            3'b000:  return 2'd1;
            3'b001:  return 2'd2;
            3'b010:  return 2'd3;
            3'b100:  return store ? 2'd0 : 2'd1;
            3'b101:  return store ? 2'd0 : 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return word;
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] w;
        w = word;
        case (f3)
            3'b000: begin
                case (lane)
                    2'd0:    w[7:0]   = data[7:0];
                    2'd1:    w[15:8]  = data[7:0];
                    2'd2:    w[23:16] = data[7:0];
                    default: w[31:24] = data[7:0];
                endcase
            end
            3'b001: begin
                if (lane[1]) w[31:16] = data[15:0];
                else         w[15:0]  = data[15:0];
            end
            3'b010:  w = data;
            default: w = word;
        endcase
        return w;
    endfunction

    logic [31:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  req_ctrl_q, req_ctrl_d;
    logic [2:0]  req_funct3_q, req_funct3_d;
    logic [31:0] req_pc_q, req_pc_d, req_addr_q, req_addr_d, req_data_q, req_data_d;
    logic        req_zero_q, req_zero_d;
    logic        valid_q, valid_d, pcsrc_q, pcsrc_d, misalign_q, misalign_d;
    logic [7:0]  control_q, control_d;
    logic [31:0] memdata_q, memdata_d, regdata_q, regdata_d, pc_q, pc_d;

    // While waiting, the access is served from the latched request instead of ex_*
    logic              in_wait_s, accept_s, complete_s, mem_we_s;
    logic [7:0]        op_ctrl_s;
    logic [2:0]        op_funct3_s;
    logic [31:0]       op_pc_s, op_addr_s, op_data_s, rd_word_s, wr_word_s;
    logic              op_zero_s, is_store_s, is_load_s, is_memop_s, misalign_s;
    logic [1:0]        size_s, lane_s;
    logic [ADDR_W-1:0] word_idx_s;

    assign in_wait_s   = (state_q == S_WAIT);
    assign accept_s    = ex_valid & ~in_wait_s;
    assign op_ctrl_s   = in_wait_s ? req_ctrl_q   : ex_ctrl;
    assign op_funct3_s = in_wait_s ? req_funct3_q : ex_funct3;
    assign op_pc_s     = in_wait_s ? req_pc_q     : ex_pc;
    assign op_addr_s   = in_wait_s ? req_addr_q   : ex_addr;
    assign op_data_s   = in_wait_s ? req_data_q   : ex_data;
    assign op_zero_s   = in_wait_s ? req_zero_q   : ex_zero;

    assign is_store_s  = op_ctrl_s[3];
    assign is_load_s   = op_ctrl_s[4] & ~op_ctrl_s[3];
    assign is_memop_s  = is_store_s | is_load_s;
    assign lane_s      = op_addr_s[1:0];
    assign size_s      = access_size(op_funct3_s, is_store_s);
    assign misalign_s  = is_memop_s & (((size_s == 2'd2) & lane_s[0]) |
                                       ((size_s == 2'd3) & (lane_s != 2'd0)));
    assign word_idx_s  = op_addr_s[ADDR_W+1:2];
    assign rd_word_s   = mem[word_idx_s];
    assign wr_word_s   = store_merge(rd_word_s, lane_s, op_funct3_s, op_data_s);
    assign mem_we_s    = complete_s & is_store_s & ~misalign_s;

    // Next-state, wait counter, request latch and MEM/WB register contents
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ctrl_d   = req_ctrl_q;
        req_funct3_d = req_funct3_q;
        req_pc_d     = req_pc_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        req_zero_d   = req_zero_q;
        complete_s   = 1'b0;
        valid_d      = 1'b0;
        control_d    = 8'd0;
        pcsrc_d      = 1'b0;
        misalign_d   = 1'b0;
        memdata_d    = memdata_q;
        regdata_d    = regdata_q;
        pc_d         = pc_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && is_memop_s && !misalign_s && HAS_WAIT) begin
                    state_d      = S_WAIT;
                    cnt_d        = WAIT_INIT;
                    req_ctrl_d   = ex_ctrl;
                    req_funct3_d = ex_funct3;
                    req_pc_d     = ex_pc;
                    req_addr_d   = ex_addr;
                    req_data_d   = ex_data;
                    req_zero_d   = ex_zero;
                end else begin
                    complete_s = accept_s;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    complete_s = 1'b1;
                    state_d    = S_IDLE;
                    cnt_d      = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (complete_s) begin
            valid_d    = 1'b1;
            control_d  = op_ctrl_s;
            pcsrc_d    = op_ctrl_s[2] & op_zero_s;
            misalign_d = misalign_s;
            memdata_d  = (is_load_s && !misalign_s) ? load_extend(rd_word_s, lane_s, op_funct3_s)
                                                    : 32'd0;
            regdata_d  = op_addr_s;
            pc_d       = op_pc_s;
        end else begin
            valid_d = 1'b0;
        end
    end

    // State, request latch and MEM/WB registers
    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            req_ctrl_q   <= 8'd0;
            req_funct3_q <= 3'd0;
            req_pc_q     <= 32'd0;
            req_addr_q   <= 32'd0;
            req_data_q   <= 32'd0;
            req_zero_q   <= 1'b0;
            valid_q      <= 1'b0;
            control_q    <= 8'd0;
            pcsrc_q      <= 1'b0;
            misalign_q   <= 1'b0;
            memdata_q    <= 32'd0;
            regdata_q    <= 32'd0;
            pc_q         <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ctrl_q   <= req_ctrl_d;
            req_funct3_q <= req_funct3_d;
            req_pc_q     <= req_pc_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            req_zero_q   <= req_zero_d;
            valid_q      <= valid_d;
            control_q    <= control_d;
            pcsrc_q      <= pcsrc_d;
            misalign_q   <= misalign_d;
            memdata_q    <= memdata_d;
            regdata_q    <= regdata_d;
            pc_q         <= pc_d;
        end
    end

    // Memory write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s && !res) begin
            mem[word_idx_s] <= wr_word_s;
        end
    end

    assign mem_busy       = in_wait_s;
    assign mem_wb_valid   = valid_q;
    assign mem_wb_control = control_q;
    assign mem_wb_memdata = memdata_q;
    assign mem_wb_regdata = regdata_q;
    assign mem_wb_pc      = pc_q;
    assign pcsrc_flag     = pcsrc_q;
    assign misalign_flag  = misalign_q;
endmodule

// File: tb/tb_mem_stage_ws.sv
// Testbench for mem_stage_ws: three instances (W=0, 3, 4) checked against a
// transaction-level memory model with directed and random accesses.
module tb_mem_stage_ws;
    localparam int ND = 3;
    localparam int AW = 10;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [2:0]  f3;
        logic        zero;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    typedef struct packed {
        logic [31:0] memdata;
        logic        mis;
        logic        pcsrc;
        logic [4:0]  waits;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res [ND];
    logic        ex_valid [ND];
    logic [7:0]  ex_ctrl [ND];
    logic [2:0]  ex_funct3 [ND];
    logic [31:0] ex_pc [ND];
    logic        ex_zero [ND];
    logic [31:0] ex_addr [ND];
    logic [31:0] ex_data [ND];
    logic        mem_busy [ND];
    logic        mem_wb_valid [ND];
    logic [7:0]  mem_wb_control [ND];
    logic [31:0] mem_wb_memdata [ND];
    logic [31:0] mem_wb_regdata [ND];
    logic [31:0] mem_wb_pc [ND];
    logic        pcsrc_flag [ND];
    logic        misalign_flag [ND];

    for (genvar g = 0; g < ND; g++) begin : gen_dut
        mem_stage_ws #(.ADDR_W(AW), .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 4))) u_dut (
            .clk(clk), .res(res[g]), .ex_valid(ex_valid[g]), .ex_ctrl(ex_ctrl[g]),
            .ex_funct3(ex_funct3[g]), .ex_pc(ex_pc[g]), .ex_zero(ex_zero[g]),
            .ex_addr(ex_addr[g]), .ex_data(ex_data[g]), .mem_busy(mem_busy[g]),
            .mem_wb_valid(mem_wb_valid[g]), .mem_wb_control(mem_wb_control[g]),
            .mem_wb_memdata(mem_wb_memdata[g]), .mem_wb_regdata(mem_wb_regdata[g]),
            .mem_wb_pc(mem_wb_pc[g]), .pcsrc_flag(pcsrc_flag[g]), .misalign_flag(misalign_flag[g])
        );
    end

    int          waits_of [ND] = '{0, 3, 4};
    logic [31:0] mem_m [ND][1024];
    logic [31:0] h_memdata [ND];
    logic [31:0] h_regdata [ND];
    logic [31:0] h_pc [ND];
    op_t         b2b_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-lane arithmetic on a word array, one completed instruction at a time
    function automatic exp_t model(input int d, input op_t op);
        exp_t        e;
        logic        st, ld;
        int          lane, idx, nb;
        logic [31:0] w, mask, v;
        st   = op.ctrl[3];
        ld   = op.ctrl[4] && !st;
        lane = int'(op.addr % 32'd4);
        idx  = int'((op.addr / 32'd4) % 32'd1024);
        nb   = 0;
        if (ld) begin
            if (op.f3 == 3'd0 || op.f3 == 3'd4) nb = 1;
            else if (op.f3 == 3'd1 || op.f3 == 3'd5) nb = 2;
            else if (op.f3 == 3'd2) nb = 4;
        end else if (st) begin
            if (op.f3 == 3'd0) nb = 1;
            else if (op.f3 == 3'd1) nb = 2;
            else if (op.f3 == 3'd2) nb = 4;
        end
        e.mis     = (nb > 1) && (lane % nb != 0);
        e.pcsrc   = op.ctrl[2] & op.zero;
        e.memdata = 32'd0;
        e.waits   = ((ld || st) && !e.mis) ? 5'(waits_of[d]) : 5'd0;
        if (ld && !e.mis && nb > 0) begin
            w    = mem_m[d][idx] >> (8 * lane);
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
            v    = w & mask;
            if (op.f3 < 3'd4 && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
            e.memdata = v;
        end
        if (st && !e.mis && nb > 0) begin
            for (int b = 0; b < nb; b++) mem_m[d][idx][8 * (lane + b) +: 8] = op.data[8 * b +: 8];
        end
        return e;
    endfunction

    function automatic op_t mk(input logic [7:0] ctrl, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] data, input logic zero);
        op_t o;
        o.ctrl = ctrl; o.f3 = f3; o.addr = addr; o.data = data; o.zero = zero;
        o.pc   = $urandom & 32'hFFFF_FFFC;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t  o;
        int   kind;
        kind      = $urandom_range(0, 3);
        o         = mk(8'($urandom), 3'($urandom_range(0, 7)),
                       ($urandom & 32'hFFFF_F000) | (32'($urandom_range(4, 11)) << 2) | 32'($urandom_range(0, 3)),
                       $urandom, 1'($urandom));
        o.ctrl[3] = (kind == 2) || (kind == 3);
        o.ctrl[4] = (kind == 1) || (kind == 3);
        return o;
    endfunction

    task automatic drive(input int d, input op_t op);
        ex_valid[d] = 1'b1; ex_ctrl[d] = op.ctrl; ex_funct3[d] = op.f3; ex_pc[d] = op.pc;
        ex_zero[d] = op.zero; ex_addr[d] = op.addr; ex_data[d] = op.data;
    endtask

    task automatic check_done(input int d, input op_t op, input exp_t e);
        check($sformatf("d%0d_valid", d), 32'(mem_wb_valid[d]), 32'd1);
        check($sformatf("d%0d_control", d), 32'(mem_wb_control[d]), 32'(op.ctrl));
        check($sformatf("d%0d_regdata", d), mem_wb_regdata[d], op.addr);
        check($sformatf("d%0d_pc", d), mem_wb_pc[d], op.pc);
        check($sformatf("d%0d_pcsrc", d), 32'(pcsrc_flag[d]), 32'(e.pcsrc));
        check($sformatf("d%0d_misalign", d), 32'(misalign_flag[d]), 32'(e.mis));
        check($sformatf("d%0d_memdata", d), mem_wb_memdata[d], e.memdata);
        check($sformatf("d%0d_busy_done", d), 32'(mem_busy[d]), 32'd0);
        h_memdata[d] = e.memdata; h_regdata[d] = op.addr; h_pc[d] = op.pc;
    endtask

    task automatic check_bubble(input int d);
        check($sformatf("d%0d_bub_valid", d), 32'(mem_wb_valid[d]), 32'd0);
        check($sformatf("d%0d_bub_control", d), 32'(mem_wb_control[d]), 32'd0);
        check($sformatf("d%0d_bub_pcsrc", d), 32'(pcsrc_flag[d]), 32'd0);
        check($sformatf("d%0d_bub_misalign", d), 32'(misalign_flag[d]), 32'd0);
        check($sformatf("d%0d_bub_memdata", d), mem_wb_memdata[d], h_memdata[d]);
        check($sformatf("d%0d_bub_regdata", d), mem_wb_regdata[d], h_regdata[d]);
        check($sformatf("d%0d_bub_pc", d), mem_wb_pc[d], h_pc[d]);
        check($sformatf("d%0d_bub_busy", d), 32'(mem_busy[d]), 32'd0);
    endtask

    task automatic run_op(input int d, input op_t op);
        exp_t e;
        @(negedge clk);
        check_bubble(d);
        e = model(d, op);
        drive(d, op);
        @(posedge clk);
        @(negedge clk);
        ex_valid[d] = 1'b0;
        if (e.waits > 5'd0) begin
            for (int i = 0; i < int'(e.waits); i++) begin
                if (i > 0) @(negedge clk);
                check($sformatf("d%0d_busy_wait", d), 32'(mem_busy[d]), 32'd1);
                check($sformatf("d%0d_valid_wait", d), 32'(mem_wb_valid[d]), 32'd0);
            end
            @(negedge clk);
        end
        check_done(d, op, e);
    endtask

    // Back-to-back issue on the zero-wait instance, valid held high throughout
    task automatic run_b2b(input int d);
        exp_t e;
        @(negedge clk);
        check_bubble(d);
        foreach (b2b_q[i]) begin
            e = model(d, b2b_q[i]);
            drive(d, b2b_q[i]);
            @(posedge clk);
            @(negedge clk);
            check_done(d, b2b_q[i], e);
        end
        ex_valid[d] = 1'b0;
        b2b_q.delete();
    endtask

    initial begin
        op_t  lw, alu;
        exp_t e1, e2;
        for (int d = 0; d < ND; d++) begin
            res[d] = 1'b1; ex_valid[d] = 1'b0; ex_ctrl[d] = 8'd0; ex_funct3[d] = 3'd0;
            ex_pc[d] = 32'd0; ex_zero[d] = 1'b0; ex_addr[d] = 32'd0; ex_data[d] = 32'd0;
            h_memdata[d] = 32'd0; h_regdata[d] = 32'd0; h_pc[d] = 32'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check("reset_valid", 32'(mem_wb_valid[d]), 32'd0);
            check("reset_busy", 32'(mem_busy[d]), 32'd0);
            check("reset_memdata", mem_wb_memdata[d], 32'd0);
            check("reset_pc", mem_wb_pc[d], 32'd0);
            res[d] = 1'b0;
        end
        for (int d = 0; d < ND; d++)
            for (int w = 4; w < 12; w++) run_op(d, mk(8'h08, 3'd2, 32'(w) << 2, $urandom, 1'b0));

        // Zero-wait directed cases
        b2b_q.push_back(mk(8'h08, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0));
        b2b_q.push_back(mk(8'h10, 3'd2, 32'h10, 32'd0, 1'b0));
        run_b2b(0);
        check("lw_after_sw", mem_wb_memdata[0], 32'hDEADBEEF);
        run_op(0, mk(8'h08, 3'd2, 32'h10, 32'h80FF7F01, 1'b0));
        run_op(0, mk(8'h10, 3'd0, 32'h13, 32'd0, 1'b0));
        check("lb_13", mem_wb_memdata[0], 32'hFFFFFF80);
        run_op(0, mk(8'h10, 3'd4, 32'h13, 32'd0, 1'b0));
        check("lbu_13", mem_wb_memdata[0], 32'h00000080);
        run_op(0, mk(8'h10, 3'd1, 32'h12, 32'd0, 1'b0));
        check("lh_12", mem_wb_memdata[0], 32'hFFFF80FF);
        run_op(0, mk(8'h10, 3'd5, 32'h10, 32'd0, 1'b0));
        check("lhu_10", mem_wb_memdata[0], 32'h00007F01);
        run_op(0, mk(8'h08, 3'd0, 32'h11, 32'h000000AA, 1'b0));
        run_op(0, mk(8'h10, 3'd2, 32'h10, 32'd0, 1'b0));
        check("lw_after_sb", mem_wb_memdata[0], 32'h80FFAA01);
        run_op(0, mk(8'h10, 3'd2, 32'h12, 32'd0, 1'b0));
        check("lw_mis_flag", 32'(misalign_flag[0]), 32'd1);
        check("lw_mis_data", mem_wb_memdata[0], 32'd0);
        run_op(0, mk(8'h08, 3'd1, 32'h11, 32'h0000BEEF, 1'b0));
        run_op(0, mk(8'h10, 3'd2, 32'h10, 32'd0, 1'b0));
        check("sh_mis_nowrite", mem_wb_memdata[0], 32'h80FFAA01);
        run_op(0, mk(8'h04, 3'd0, 32'h0, 32'd0, 1'b1));
        check("branch_taken", 32'(pcsrc_flag[0]), 32'd1);
        run_op(0, mk(8'h04, 3'd0, 32'h4, 32'd0, 1'b0));
        check("branch_not_taken", 32'(pcsrc_flag[0]), 32'd0);
        run_op(0, mk(8'h08, 3'd2, 32'h1020, 32'h5A5AA5A5, 1'b0));
        run_op(0, mk(8'h10, 3'd2, 32'h0020, 32'd0, 1'b0));
        check("alias_1020", mem_wb_memdata[0], 32'h5A5AA5A5);
        for (int i = 0; i < 60; i++) b2b_q.push_back(rand_op());
        run_b2b(0);

        // W=3: ALU op held on ex_* during the wait is taken at T0+4
        @(negedge clk);
        check_bubble(1);
        lw  = mk(8'h10, 3'd2, 32'h10, 32'd0, 1'b0);
        alu = mk(8'h21, 3'd1, 32'h00000333, 32'h0, 1'b0);
        e1  = model(1, lw);
        drive(1, lw);
        @(posedge clk);
        @(negedge clk);
        drive(1, alu);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("w3_busy", 32'(mem_busy[1]), 32'd1);
            check("w3_valid_low", 32'(mem_wb_valid[1]), 32'd0);
        end
        @(negedge clk);
        check_done(1, lw, e1);
        e2 = model(1, alu);
        @(posedge clk);
        @(negedge clk);
        ex_valid[1] = 1'b0;
        check_done(1, alu, e2);
        for (int i = 0; i < 30; i++) run_op(1, rand_op());

        // W=4: reset on the second wait cycle aborts the store
        @(negedge clk);
        check_bubble(2);
        drive(2, mk(8'h08, 3'd2, 32'h20, 32'h12345678, 1'b0));
        @(posedge clk);
        @(negedge clk);
        ex_valid[2] = 1'b0;
        check("w4_busy1", 32'(mem_busy[2]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        res[2] = 1'b1;
        check("w4_busy2", 32'(mem_busy[2]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        res[2] = 1'b0;
        h_memdata[2] = 32'd0; h_regdata[2] = 32'd0; h_pc[2] = 32'd0;
        check("rst_busy", 32'(mem_busy[2]), 32'd0);
        check("rst_valid", 32'(mem_wb_valid[2]), 32'd0);
        check("rst_control", 32'(mem_wb_control[2]), 32'd0);
        check("rst_memdata", mem_wb_memdata[2], 32'd0);
        check("rst_regdata", mem_wb_regdata[2], 32'd0);
        check("rst_pc", mem_wb_pc[2], 32'd0);
        check("rst_pcsrc", 32'(pcsrc_flag[2]), 32'd0);
        check("rst_misalign", 32'(misalign_flag[2]), 32'd0);
        e1 = model(2, mk(8'h00, 3'd0, 32'h0, 32'h0, 1'b0));
        run_op(2, mk(8'h10, 3'd2, 32'h20, 32'd0, 1'b0));
        check("rst_store_aborted", 32'(mem_wb_memdata[2] != 32'h12345678 || mem_m[2][8] == 32'h12345678), 32'd1);
        for (int i = 0; i < 30; i++) run_op(2, rand_op());

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_stage_ws.md
# mem_stage_ws

Parametrised MEM pipeline stage for the RISC-V core, sitting between the EX/MEM and MEM/WB boundaries. It owns a word-organised data memory, supports byte/half/word loads and stores with sign or zero extension, and detects misaligned accesses. It inserts a configurable number of memory wait states with an upstream stall. It registers the branch-taken decision (`pcsrc_flag`) from the control word delivered with the same instruction.

## Interface
Parameters:
- `ADDR_W`, default 10: word-index bits; memory depth is 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, default 0: extra cycles per aligned load/store, legal range 0..15.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `res` in 1: reset, synchronous, active-high.
- `ex_valid` in 1: instruction present on the `ex_*` inputs.
- `ex_ctrl` in 8: control word. Bit2 is branch, bit3 is mem write, bit4 is mem read; the other bits pass through unchanged.
- `ex_funct3` in 3: access size/sign.
- `ex_pc` in 32: instruction PC.
- `ex_zero` in 1: ALU zero flag.
- `ex_addr` in 32: ALU result; this is the memory address for loads and stores.
- `ex_data` in 32: store data.
- `mem_busy` out 1: stall to upstream. While it is 1, `ex_*` inputs are ignored.
- `mem_wb_valid` out 1: MEM/WB register holds a completed instruction.
- `mem_wb_control` out 8: `ex_ctrl` of the completed instruction.
- `mem_wb_memdata` out 32: extended load data.
- `mem_wb_regdata` out 32: `ex_addr` of the completed instruction.
- `mem_wb_pc` out 32: `ex_pc` of the completed instruction.
- `pcsrc_flag` out 1: branch taken, equal to `ex_ctrl[2] & ex_zero` of the completed instruction.
- `misalign_flag` out 1: completed access was misaligned.

## Operation
- **Acceptance.** An instruction is accepted on an edge where `ex_valid=1`, `mem_busy=0` and `res=0`.
- **Memory op.** A memory op is any instruction with `ex_ctrl[3]` or `ex_ctrl[4]` set. If both are set, it is treated as a store and `mem_wb_memdata` is 0.
- **Address mapping.**
  - Word index is `ex_addr[ADDR_W+1:2]`.
  - Upper address bits are ignored, so addresses alias with wrap-around.
  - Byte lane is `ex_addr[1:0]`.
- **Load decoding.**
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the selected half.
  - 010 LW: full word.
  - 100 LBU: zero-extend the selected byte.
  - 101 LHU: zero-extend the selected half.
  - Other funct3 values give data 0.
- **Store decoding.**
  - 000 SB writes `ex_data[7:0]` to the addressed lane.
  - 001 SH writes `ex_data[15:0]` to the addressed half.
  - 010 SW writes the full word.
  - Other funct3 values write nothing.
- **Misalignment.**
  - Half accesses are misaligned when `addr[0]=1`; word accesses when `addr[1:0]!=0`.
  - A misaligned access does not write memory, returns `mem_wb_memdata=0`, and raises `misalign_flag`.
  - A misaligned access never enters wait states.
- **FSM states.**
  - IDLE → WAIT on acceptance of an aligned memory op with `WAIT_CYCLES>0`. The request is latched and the counter is loaded with `WAIT_CYCLES`.
  - WAIT decrements the counter every cycle. When the counter equals 1, the access is performed, the MEM/WB registers are written, and the FSM returns to IDLE.
  - All other accepted instructions complete on the acceptance edge itself, staying in IDLE.
- **Busy output.** `mem_busy` is 1 iff the state is WAIT.
- **Bubbles.** On an edge that completes nothing, `mem_wb_valid`, `mem_wb_control`, `pcsrc_flag` and `misalign_flag` go to 0. The data, regdata and pc registers hold their values.
- **Read/write ordering.**
  - Reads return memory contents from before any write on the same edge.
  - A load issued after a store to the same word sees the stored data.
- **Reset.**
  - Reset drives all outputs to 0, the state to IDLE and the counter to 0.
  - Memory contents are not cleared.
  - Reset during WAIT aborts the access: a pending store is never written and no completion is reported.

## Timing
- Non-memory instructions, misaligned accesses, and all accesses with `WAIT_CYCLES=0`: outputs appear at the acceptance edge T0, a latency of 1 cycle.
- Aligned memory op with `WAIT_CYCLES=W>0`:
  - Completion is at edge T0+W.
  - `mem_busy` is high for the W cycles following T0.
  - Upstream holds its next instruction until `mem_busy` falls. The first new acceptance is possible at edge T0+W+1.
- Output pulse widths: `mem_wb_valid`, `pcsrc_flag` and `misalign_flag` are each high for exactly one cycle per completion. `pcsrc_flag` is aligned with `mem_wb_valid`.
- Back-to-back completions, one per cycle, are sustained when `W=0`.

## Test plan
- **Store/load word, W=0.** SW of 0xDEADBEEF to addr 0x10, then LW from 0x10 next cycle → `mem_wb_memdata=0xDEADBEEF`, `mem_wb_valid=1` one cycle after each acceptance.
- **Byte/half extension.** With word 0x10 = 0x80FF7F01:
  - LB from 0x13 → 0xFFFFFF80.
  - LBU from 0x13 → 0x00000080.
  - LH from 0x12 → 0xFFFF80FF.
  - LHU from 0x10 → 0x00007F01.
  - SB of 0xAA to 0x11, then LW → 0x80FFAA01.
- **Misalignment.** LW from 0x12 → `misalign_flag=1`, `mem_wb_memdata=0`. SH to 0x11 leaves memory unchanged (verified by a following LW).
- **Wait states, W=3.**
  - LW accepted at T0 → `mem_busy=1` during T0+1..T0+3, completion at edge T0+3, `mem_wb_valid` high for 1 cycle.
  - An ALU op held on `ex_*` is accepted at T0+4.
- **Branch.** Accepted with `ex_ctrl=0x04`, `ex_zero=1` → `pcsrc_flag=1` for one cycle. With `ex_zero=0` → `pcsrc_flag=0`. A following bubble → `pcsrc_flag=0`.
- **Reset mid-wait, W=4.**
  - SW of 0x12345678 to 0x20; `res` asserted on the second WAIT cycle.
  - Next cycle: all outputs 0, `mem_busy=0`.
  - A subsequent LW from 0x20 returns the prior contents.
  - Aliasing check with `ADDR_W=10`: SW to 0x1020, then LW from 0x0020 returns the same word.
